// File: rtl/legv8_cache_ctrl.sv
// legv8_cache_ctrl: sequencing controller for the LEGv8 4-way set-associative
// tag cache. One CPU lookup in flight at a time; misses fetch the line over a
// req/ack handshake and install the tag into a round-robin victim way chosen
// per index. Saturating hit/miss statistics counters.
module legv8_cache_ctrl #(
  parameter int ADDR_W   = 64,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = 57,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_hit,
  output logic [INDEX_W-1:0] cache_index,
  output logic [TAG_W-1:0]  cache_tag,
  output logic [3:0]        cache_write,
  input  logic              hit_status,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int NIDX   = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_WAIT, S_FILL, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [LINE_W-1:0]  line_q, line_d;   // latched address without byte offset
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [1:0]         victim_q [NIDX];
  logic [INDEX_W-1:0] idx;

  // Byte-offset bits never reach the cache or memory; line-aligned only.
  logic unused_offset;
  assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

  assign idx         = line_q[INDEX_W-1:0];
  assign cache_index = idx;
  assign cache_tag   = line_q[LINE_W-1 -: TAG_W];
  assign mem_addr    = {line_q, {OFFSET_W{1'b0}}};
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

  // State, latched address, hit flag and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      line_q     <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state logic and the LOOKUP-time bookkeeping (hit flag, statistics).
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    hit_d      = hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          line_d  = cpu_addr[ADDR_W-1:OFFSET_W];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = hit_status;
        if (hit_status) begin
          state_d = S_RESP;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
        end else begin
          state_d = S_MEM_WAIT;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
        end
      end
      S_MEM_WAIT: if (mem_ack) state_d = S_FILL;
      S_FILL:     state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset clears them immediately.
  always_comb begin
    cpu_busy    = (state_q != S_IDLE);
    cpu_done    = (state_q == S_RESP);
    cpu_hit     = (state_q == S_RESP) && hit_q;
    mem_req     = (state_q == S_MEM_WAIT);
    cache_write = 4'b0000;
    if (state_q == S_FILL) cache_write[victim_q[idx]] = 1'b1;
  end

  // Per-index round-robin victim pointers; advance only when a way is filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NIDX; i++) victim_q[i] <= 2'd0;
    end else if (state_q == S_FILL) begin
      victim_q[idx] <= victim_q[idx] + 2'd1;
    end
  end

endmodule

// File: tb/tb_legv8_cache_ctrl.sv
// Bench for legv8_cache_ctrl: directed table (cold miss, hit, replacement),
// randomized lookups against a tag-store reference model, and async reset
// cases including reset during a pending fetch.
module tb_legv8_cache_ctrl;

  localparam int ADDR_W = 64, INDEX_W = 5, OFFSET_W = 2, TAG_W = 57;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0, rst = 1'b0;
  logic              cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_busy, cpu_done, cpu_hit;
  logic [INDEX_W-1:0] cache_index;
  logic [TAG_W-1:0]  cache_tag;
  logic [3:0]        cache_write;
  logic              hit_status = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [CNT_W-1:0]  hit_count, miss_count;

  legv8_cache_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W),
                     .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
    .cache_index(cache_index), .cache_tag(cache_tag), .cache_write(cache_write),
    .hit_status(hit_status), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the 4-way tag array holds, round-robin fill
  // pointers per index, and saturating statistics.
  logic [TAG_W-1:0] m_tag [32][4];
  bit               m_val [32][4];
  int               m_ptr [32];
  int               m_hits, m_miss;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_ptr[i] = 0;
      for (int w = 0; w < 4; w++) begin m_val[i][w] = 0; m_tag[i][w] = '0; end
    end
    m_hits = 0; m_miss = 0;
  endtask

  task automatic model_access(input logic [63:0] a, output bit hit, output logic [3:0] wr);
    int ix;
    logic [TAG_W-1:0] tg;
    ix = int'(a[6:2]);
    tg = a[63:7];
    hit = 0;
    wr  = 4'b0000;
    for (int w = 0; w < 4; w++) if (m_val[ix][w] && m_tag[ix][w] == tg) hit = 1;
    if (hit) begin
      if (m_hits < CMAX) m_hits++;
    end else begin
      wr = 4'b0001 << m_ptr[ix];
      m_tag[ix][m_ptr[ix]] = tg;
      m_val[ix][m_ptr[ix]] = 1;
      m_ptr[ix] = (m_ptr[ix] + 1) % 4;
      if (m_miss < CMAX) m_miss++;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", cpu_busy, 0);   chk("rst_done", cpu_done, 0);
    chk("rst_hit", cpu_hit, 0);     chk("rst_memreq", mem_req, 0);
    chk("rst_write", cache_write, 0);
    chk("rst_index", cache_index, 0); chk("rst_tag", cache_tag, 0);
    chk("rst_memaddr", mem_addr, 0);
    chk("rst_hitcnt", hit_count, 0); chk("rst_misscnt", miss_count, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("post_rst_busy", cpu_busy, 0);
    chk("post_rst_cnt", {hit_count, miss_count}, 0);
  endtask

  // One full transaction from an IDLE cycle; dly = MEM_WAIT cycles (ack in last).
  task automatic txn(input logic [63:0] a, input int dly, input bit exp_hit,
                     input logic [3:0] exp_wr);
    logic [63:0] la;
    la = {a[63:2], 2'b00};
    cpu_req = 1'b1; cpu_addr = a;
    @(posedge clk); #1;
    // LOOKUP: stray requests and acks here must be ignored
    cpu_req = 1'($urandom); cpu_addr = {$urandom, $urandom};
    mem_ack = 1'($urandom); hit_status = exp_hit;
    chk("lk_busy", cpu_busy, 1); chk("lk_done", cpu_done, 0);
    chk("lk_memreq", mem_req, 0); chk("lk_write", cache_write, 0);
    chk("lk_index", cache_index, a[6:2]); chk("lk_tag", cache_tag, a[63:7]);
    @(posedge clk); #1;
    hit_status = 1'($urandom);
    cpu_req = 1'($urandom);
    if (!exp_hit) begin
      for (int k = 1; k <= dly; k++) begin
        mem_ack = (k == dly);
        chk("mw_memreq", mem_req, 1); chk("mw_memaddr", mem_addr, la);
        chk("mw_write", cache_write, 0); chk("mw_done", cpu_done, 0);
        @(posedge clk); #1;
      end
      mem_ack = 1'($urandom);
      chk("fill_write", cache_write, exp_wr);
      chk("fill_memreq", mem_req, 0); chk("fill_done", cpu_done, 0);
      @(posedge clk); #1;
    end
    chk("resp_done", cpu_done, 1); chk("resp_hit", cpu_hit, exp_hit);
    chk("resp_write", cache_write, 0); chk("resp_memreq", mem_req, 0);
    mem_ack = 1'($urandom); cpu_req = 1'($urandom);
    @(posedge clk); #1;
    cpu_req = 1'b0; mem_ack = 1'b0;
    chk("idle_busy", cpu_busy, 0); chk("idle_done", cpu_done, 0);
    chk("hit_count", hit_count, m_hits[CNT_W-1:0]);
    chk("miss_count", miss_count, m_miss[CNT_W-1:0]);
    @(posedge clk); #1;
    chk("noqueue_busy", cpu_busy, 0);
  endtask

  typedef struct {
    bit          rst_b;
    logic [63:0] a;
    int          dly;
    bit          hit;
    logic [3:0]  wr;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit          h;
    logic [3:0]  w;
    logic [63:0] a;

    tbl[0] = '{0, 64'h100, 3, 0, 4'b0001};  // cold miss, index 0 tag 2
    tbl[1] = '{0, 64'h100, 1, 1, 4'b0000};  // hit
    tbl[2] = '{1, 64'h000, 1, 0, 4'b0001};  // replacement walk on index 0
    tbl[3] = '{0, 64'h080, 2, 0, 4'b0010};
    tbl[4] = '{0, 64'h100, 1, 0, 4'b0100};
    tbl[5] = '{0, 64'h180, 4, 0, 4'b1000};
    tbl[6] = '{0, 64'h200, 1, 0, 4'b0001};
    tbl[7] = '{0, 64'h004, 2, 0, 4'b0001};  // index 1 starts at way 0
    tbl[8] = '{0, 64'h080, 1, 1, 4'b0000};  // tag 1 still in way 1
    tbl[9] = '{0, 64'h000, 1, 0, 4'b0010};  // tag 0 evicted earlier

    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst_b) do_reset();
      model_access(tbl[i].a, h, w);  // keeps model in step for counters
      txn(tbl[i].a, tbl[i].dly, tbl[i].hit, tbl[i].wr);
    end

    // Random lookups over a small index/tag space to mix hits and misses;
    // the counters are narrow so saturation is reached here.
    for (int i = 0; i < 40; i++) begin
      a = (64'($urandom_range(5)) << 7) | (64'($urandom_range(3)) << 2)
          | 64'($urandom_range(3));
      model_access(a, h, w);
      txn(a, int'($urandom_range(4, 1)), h, w);
    end

    // Reset while a fetch is pending: no completion, pointers back to way 0.
    cpu_req = 1'b1; cpu_addr = 64'h1234;
    @(posedge clk); #1;
    cpu_req = 1'b0; hit_status = 1'b0;
    @(posedge clk); #1;
    chk("mw_rst_pre_memreq", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("mw_rst_memreq", mem_req, 0); chk("mw_rst_busy", cpu_busy, 0);
    chk("mw_rst_write", cache_write, 0);
    @(negedge clk) rst = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 0);
      @(posedge clk); #1;
      chk("mw_rst_nodone", cpu_done, 0);
      chk("mw_rst_idle", cpu_busy, 0);
    end
    mem_ack = 1'b0;
    model_access(64'h3000, h, w);
    txn(64'h3000, 1, 0, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
